// File: rtl/bank_stream_reader.sv
// bank_stream_reader: read-side master for one byte-wide dual-port bank.
// Walks a contiguous byte region through the bank's combinational read port
// and presents it on a valid/ready byte stream with a last marker.
// Build option BANK_READER_WRAP_EN: regions that run past the top of the bank
// are accepted and the address wraps to 0; otherwise they are rejected.
// mem_addr is registered: the address is issued one cycle before its byte is
// captured, then advanced together with each capture so steady state runs at
// one byte per cycle.

module bank_stream_reader #(
  parameter int DATA_DEPTH   = 4096,
  parameter int STALL_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(DATA_DEPTH)-1:0] start_addr,
  input  logic [$clog2(DATA_DEPTH):0]   length,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(DATA_DEPTH)-1:0] mem_addr,
  input  logic [7:0]                    mem_data,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;

  logic [AW-1:0] ptr_r;
  logic [AW-1:0] mem_addr_r;
  logic [LW-1:0] remaining_r;
  logic [CW-1:0] wait_cnt_r;
  logic          addr_ok_r;
  logic [7:0]    m_data_r;
  logic          m_valid_r;
  logic          m_last_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic          len_zero_s;
  logic          len_over_s;
  logic          range_over_s;
  logic          accept_s;
  logic          zero_req_s;
  logic          reject_s;
  logic          out_free_s;
  logic          beat_s;
  logic          fire_s;
  logic          last_fire_s;
  logic          wait_over_s;
  logic          flush_done_s;

  // Classify an incoming request: empty, longer than the bank, or past the top.
  always_comb begin
    len_zero_s = (length == {LW{1'b0}});
    len_over_s = (length > LW'(DATA_DEPTH));
`ifdef BANK_READER_WRAP_EN
    range_over_s = 1'b0;
`else
    range_over_s = (({1'b0, start_addr} + length) > LW'(DATA_DEPTH));
`endif
  end

  // Per-cycle control strobes decoded from the current state and handshake.
  always_comb begin
    accept_s     = 1'b0;
    zero_req_s   = 1'b0;
    reject_s     = 1'b0;
    fire_s       = 1'b0;
    wait_over_s  = 1'b0;
    flush_done_s = 1'b0;
    out_free_s   = !m_valid_r || m_ready;
    beat_s       = m_valid_r && m_ready;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (len_over_s || range_over_s) begin
            reject_s = 1'b1;
          end else if (len_zero_s) begin
            zero_req_s = 1'b1;
          end else begin
            accept_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      S_FETCH: fire_s = addr_ok_r && out_free_s;
      S_WAIT:  wait_over_s = (wait_cnt_r == CW'(STALL_CYCLES - 1));
      S_FLUSH: flush_done_s = beat_s && m_last_r;
      default: accept_s = 1'b0;
    endcase
    last_fire_s = fire_s && (remaining_r == LW'(1));
  end

  // Next-state selection.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx_s = S_FETCH;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (last_fire_s) begin
          state_nx_s = S_FLUSH;
        end else if (fire_s && (STALL_CYCLES > 0)) begin
          state_nx_s = S_WAIT;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_WAIT: begin
        if (wait_over_s) begin
          state_nx_s = S_FETCH;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (flush_done_s) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_FLUSH;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request, address, wait-counter and stream output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r       <= {AW{1'b0}};
      mem_addr_r  <= {AW{1'b0}};
      remaining_r <= {LW{1'b0}};
      wait_cnt_r  <= {CW{1'b0}};
      addr_ok_r   <= 1'b0;
      m_data_r    <= 8'h00;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= zero_req_s || flush_done_s;
      err_r  <= reject_s;

      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (flush_done_s) begin
        busy_r <= 1'b0;
      end

      // First FETCH cycle only issues the address; later captures advance it.
      if (accept_s) begin
        ptr_r       <= start_addr;
        remaining_r <= length;
        addr_ok_r   <= 1'b0;
      end else if ((state_r == S_FETCH) && !addr_ok_r) begin
        mem_addr_r  <= ptr_r;
        addr_ok_r   <= 1'b1;
      end else if (fire_s) begin
        ptr_r       <= ptr_r + AW'(1);
        remaining_r <= remaining_r - LW'(1);
        mem_addr_r  <= last_fire_s ? ptr_r : (ptr_r + AW'(1));
      end

      if (fire_s) begin
        wait_cnt_r <= {CW{1'b0}};
      end else if (state_r == S_WAIT) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end

      if (fire_s) begin
        m_data_r  <= mem_data;
        m_valid_r <= 1'b1;
        m_last_r  <= last_fire_s;
      end else if (beat_s) begin
        m_valid_r <= 1'b0;
        m_last_r  <= 1'b0;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign mem_addr = mem_addr_r;
  assign m_data   = m_data_r;
  assign m_valid  = m_valid_r;
  assign m_last   = m_last_r;

endmodule

// File: tb/tb_bank_stream_reader.sv
// Bench for bank_stream_reader: one instance with back-to-back fetches driven
// from a vector table, one instance with two stall cycles for the mid-transfer
// restart and reset sequences. Expected bytes go into a queue at request time
// and are popped on every stream handshake.

module tb_bank_stream_reader;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int LW    = 13;
`ifdef BANK_READER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:DEPTH-1];

  logic          rst_n_a, start_a, busy_a, done_a, err_a;
  logic          m_valid_a, m_ready_a, m_last_a;
  logic [AW-1:0] start_addr_a, mem_addr_a;
  logic [LW-1:0] length_a;
  logic [7:0]    mem_data_a, m_data_a;

  logic          rst_n_b, start_b, busy_b, done_b, err_b;
  logic          m_valid_b, m_ready_b, m_last_b;
  logic [AW-1:0] start_addr_b, mem_addr_b;
  logic [LW-1:0] length_b;
  logic [7:0]    mem_data_b, m_data_b;

  assign mem_data_a = mem[mem_addr_a];
  assign mem_data_b = mem[mem_addr_b];

  bank_stream_reader #(.DATA_DEPTH(DEPTH), .STALL_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .start_addr(start_addr_a),
    .length(length_a), .busy(busy_a), .done(done_a), .err(err_a),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .m_data(m_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_last(m_last_a)
  );

  bank_stream_reader #(.DATA_DEPTH(DEPTH), .STALL_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .start_addr(start_addr_b),
    .length(length_b), .busy(busy_b), .done(done_b), .err(err_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .m_data(m_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [7:0]    rdy;
    bit            exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One table row on the zero-stall instance.
  task automatic run_a(input vec_t v);
    int   first_k = -1;
    int   last_k  = -1;
    int   done_k  = -1;
    int   err_k   = -1;
    int   hs_n    = 0;
    int   done_n  = 0;
    int   err_n   = 0;
    bit   stalled = 1'b0;
    bit   valid_req;
    logic [7:0] held_d;
    logic       held_l;
    logic [7:0] exp_d;
    valid_req = !v.exp_err && (v.len != '0);
    held_d = 8'h00;
    held_l = 1'b0;
    if (valid_req) begin
      for (int i = 0; i < int'(v.len); i++) exp_q.push_back(mem[(int'(v.addr) + i) % DEPTH]);
    end
    @(negedge clk);
    start_a = 1'b1; start_addr_a = v.addr; length_a = v.len; m_ready_a = v.rdy[0];
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (k == 1) check($sformatf("v%0d_busy_k1", v.id), busy_a, valid_req);
      if (stalled) begin
        check($sformatf("v%0d_hold_valid_k%0d", v.id, k), m_valid_a, 1'b1);
        check($sformatf("v%0d_hold_data_k%0d", v.id, k), m_data_a, held_d);
        check($sformatf("v%0d_hold_last_k%0d", v.id, k), m_last_a, held_l);
      end
      if (m_valid_a && first_k < 0) first_k = k;
      if (done_a) begin
        done_n++; done_k = k;
        check($sformatf("v%0d_busy_at_done", v.id), busy_a, 1'b0);
      end
      if (err_a) begin
        err_n++; err_k = k;
      end
      m_ready_a = v.rdy[k % 8];
      stalled = m_valid_a && !m_ready_a;
      held_d = m_data_a;
      held_l = m_last_a;
      if (m_valid_a && m_ready_a) begin
        hs_n++; last_k = k;
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_extra_beat", v.id), hs_n, int'(v.len));
        end else begin
          exp_d = exp_q.pop_front();
          check($sformatf("v%0d_data_b%0d", v.id, hs_n), m_data_a, exp_d);
          check($sformatf("v%0d_last_b%0d", v.id, hs_n), m_last_a, exp_q.size() == 0);
        end
      end
    end
    check($sformatf("v%0d_beats", v.id), hs_n, valid_req ? int'(v.len) : 0);
    check($sformatf("v%0d_leftover", v.id), exp_q.size(), 0);
    exp_q.delete();
    check($sformatf("v%0d_err_n", v.id), err_n, v.exp_err);
    check($sformatf("v%0d_done_n", v.id), done_n, !v.exp_err);
    if (valid_req) begin
      check($sformatf("v%0d_first_lat", v.id), first_k, 3);
      check($sformatf("v%0d_done_k", v.id), done_k, last_k + 1);
      check($sformatf("v%0d_mem_addr_idle", v.id), mem_addr_a, (int'(v.addr) + int'(v.len) - 1) % DEPTH);
      if (v.rdy == 8'hFF) check($sformatf("v%0d_no_bubble", v.id), last_k, first_k + int'(v.len) - 1);
    end else if (v.exp_err) begin
      check($sformatf("v%0d_err_k", v.id), err_k, 1);
    end else begin
      check($sformatf("v%0d_zero_done_k", v.id), done_k, 1);
      check($sformatf("v%0d_zero_first", v.id), first_k, -1);
    end
  endtask

  // Stalled-fetch instance: optional ignored restart and optional reset after N beats.
  task automatic run_b(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input int restart_k, input int reset_after);
    int   first_k = -1;
    int   last_k  = -1;
    int   done_k  = -1;
    int   hs_n    = 0;
    int   done_n  = 0;
    bit   pend_rst = 1'b0;
    bit   in_rst   = 1'b0;
    int   exp_beats;
    logic [7:0] exp_d;
    exp_beats = (reset_after > 0) ? reset_after : int'(len);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[(int'(addr) + i) % DEPTH]);
    @(negedge clk);
    start_b = 1'b1; start_addr_b = addr; length_b = len; m_ready_b = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (k == restart_k) begin
        start_b = 1'b1; start_addr_b = 12'd200; length_b = 13'd3;
      end
      if (in_rst) begin
        check($sformatf("s%0d_rst_valid", id), m_valid_b, 1'b0);
        check($sformatf("s%0d_rst_busy", id), busy_b, 1'b0);
        check($sformatf("s%0d_rst_done", id), done_b, 1'b0);
        rst_n_b = 1'b1; in_rst = 1'b0;
      end
      if (pend_rst) begin
        rst_n_b = 1'b0; in_rst = 1'b1; pend_rst = 1'b0;
      end
      if (done_b) begin
        done_n++; done_k = k;
      end
      if (m_valid_b && first_k < 0) first_k = k;
      if (m_valid_b && rst_n_b) begin
        hs_n++;
        if (last_k > 0) check($sformatf("s%0d_spacing_b%0d", id, hs_n), k - last_k, 3);
        last_k = k;
        if (exp_q.size() == 0) begin
          check($sformatf("s%0d_extra_beat", id), hs_n, exp_beats);
        end else begin
          exp_d = exp_q.pop_front();
          check($sformatf("s%0d_data_b%0d", id, hs_n), m_data_b, exp_d);
          check($sformatf("s%0d_last_b%0d", id, hs_n), m_last_b, hs_n == int'(len));
        end
        if (reset_after > 0 && hs_n == reset_after) pend_rst = 1'b1;
      end
    end
    check($sformatf("s%0d_beats", id), hs_n, exp_beats);
    check($sformatf("s%0d_leftover", id), exp_q.size(), int'(len) - exp_beats);
    exp_q.delete();
    check($sformatf("s%0d_first_lat", id), first_k, 3);
    check($sformatf("s%0d_done_n", id), done_n, (reset_after > 0) ? 0 : 1);
    if (reset_after == 0) check($sformatf("s%0d_done_k", id), done_k, last_k + 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = i[7:0];
    rst_n_a = 1'b0; start_a = 1'b0; start_addr_a = '0; length_a = '0; m_ready_a = 1'b0;
    rst_n_b = 1'b0; start_b = 1'b0; start_addr_b = '0; length_b = '0; m_ready_b = 1'b0;

    vecs[0] = '{0, 12'd16,   13'd4,    8'hFF,        1'b0};
    vecs[1] = '{1, 12'd16,   13'd4,    8'b0100_1011, 1'b0};
    vecs[2] = '{2, 12'd0,    13'd0,    8'hFF,        1'b0};
    vecs[3] = '{3, 12'd4094, 13'd4,    8'hFF,        !WRAP};
    vecs[4] = '{4, 12'd0,    13'd4097, 8'hFF,        1'b1};
    vecs[5] = '{5, 12'd4092, 13'd4,    8'hFF,        1'b0};
    vecs[6] = '{6, 12'd100,  13'd1,    8'b0011_0000, 1'b0};
    vecs[7] = '{7, 12'd4095, 13'd2,    8'b1010_1010, !WRAP};

    repeat (3) @(negedge clk);
    check("rst_valid_a", m_valid_a, 1'b0);
    check("rst_data_a", m_data_a, 8'h00);
    check("rst_last_a", m_last_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_err_a", err_a, 1'b0);
    check("rst_addr_a", mem_addr_a, 12'd0);
    check("rst_valid_b", m_valid_b, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    for (int v = 0; v < 8; v++) run_a(vecs[v]);

    run_b(0, 12'd0,  13'd8, 5, 0);
    run_b(1, 12'd0,  13'd8, 0, 3);
    run_b(2, 12'd32, 13'd3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
